// File: rtl/decoder_pipe_e.sv
// -----------------------------------------------------------------------------
// decoder_pipe_e
//
// Pipelined binary-to-one-hot / thermometer decoder with valid/ready flow
// control and a two-entry skid buffer (main + skid register). The index is
// decoded on the input side, so each buffered entry already holds the final
// {word, err} pair. The outputs are driven directly from the main register.
//
// Parameters
//   IN_WIDTH     index width in bits (1..8)
//   NUM_OUTPUTS  number of decoded lines (2..2**IN_WIDTH)
//   THERMO       0 = one-hot decode, 1 = thermometer decode
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   rst_ni       synchronous active-low reset
//   in_i         index to decode
//   enable_i     decode enable; 0 yields an all-zero word that still flows
//   valid_i      upstream offers a transaction
//   ready_o      block can accept a transaction this cycle (registered)
//   out_o        decoded word of the head transaction (0 when not valid)
//   range_err_o  head transaction had an enabled, out-of-range index
//   valid_o      out_o / range_err_o carry a valid transaction
//   ready_i      downstream takes the head transaction this cycle
// -----------------------------------------------------------------------------
module decoder_pipe_e #(
  parameter int IN_WIDTH    = 5,
  parameter int NUM_OUTPUTS = 2 ** IN_WIDTH,
  parameter int THERMO      = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [IN_WIDTH-1:0]    in_i,
  input  logic                   enable_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [NUM_OUTPUTS-1:0] out_o,
  output logic                   range_err_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  // Reject illegal parameter combinations at elaboration time.
  if (IN_WIDTH < 1 || IN_WIDTH > 8) begin : g_bad_in_width
    $error("decoder_pipe_e: IN_WIDTH must be in 1..8");
  end
  if (NUM_OUTPUTS < 2 || NUM_OUTPUTS > (2 ** IN_WIDTH)) begin : g_bad_num_outputs
    $error("decoder_pipe_e: NUM_OUTPUTS must be in 2..2**IN_WIDTH");
  end

  // NUM_OUTPUTS can equal 2**IN_WIDTH, so one extra bit is needed to hold it.
  localparam logic [IN_WIDTH:0] NUM_OUT_W = (IN_WIDTH + 1)'(NUM_OUTPUTS);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Decode one index into {word, err}. Out-of-range enabled indices give a
  // zero word with err set; a disabled request is always a clean zero.
  function automatic logic [NUM_OUTPUTS:0] decode_f(
    input logic [IN_WIDTH-1:0] idx,
    input logic                en
  );
    logic [NUM_OUTPUTS-1:0] word;
    logic                   err;
    logic [31:0]            idx32;
    word  = '0;
    err   = 1'b0;
    idx32 = 32'(idx);
    if (!en) begin
      word = '0;
      err  = 1'b0;
    end else if ({1'b0, idx} >= NUM_OUT_W) begin
      word = '0;
      err  = 1'b1;
    end else begin
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        if (THERMO != 0) begin
          word[k] = (32'(k) <= idx32);
        end else begin
          word[k] = (32'(k) == idx32);
        end
      end
      err = 1'b0;
    end
    return {word, err};
  endfunction

  state_e                 state_r;
  logic [NUM_OUTPUTS-1:0] main_word_r;
  logic                   main_err_r;
  logic [NUM_OUTPUTS-1:0] skid_word_r;
  logic                   skid_err_r;
  logic                   valid_r;
  logic                   ready_r;

  logic [NUM_OUTPUTS:0]   dec_s;
  logic                   accept_s;

  // Input-side decode and handshake qualification. ready_r is purely a
  // function of the registered state, so ready_i never reaches ready_o.
  always_comb begin
    dec_s    = decode_f(in_i, enable_i);
    accept_s = valid_i && ready_r;
  end

  // Skid-buffer controller: state, data registers and registered handshakes.
  // The main register is cleared whenever it empties so that out_o and
  // range_err_o read zero while valid_o is low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= ST_EMPTY;
      main_word_r <= '0;
      main_err_r  <= 1'b0;
      skid_word_r <= '0;
      skid_err_r  <= 1'b0;
      valid_r     <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            main_word_r <= dec_s[NUM_OUTPUTS:1];
            main_err_r  <= dec_s[0];
            state_r     <= ST_ONE;
            valid_r     <= 1'b1;
            ready_r     <= 1'b1;
          end else begin
            state_r <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && ready_i) begin
            // Head leaves and the new entry replaces it in the same edge.
            main_word_r <= dec_s[NUM_OUTPUTS:1];
            main_err_r  <= dec_s[0];
            state_r     <= ST_ONE;
          end else if (accept_s) begin
            skid_word_r <= dec_s[NUM_OUTPUTS:1];
            skid_err_r  <= dec_s[0];
            state_r     <= ST_TWO;
            ready_r     <= 1'b0;
          end else if (ready_i) begin
            main_word_r <= '0;
            main_err_r  <= 1'b0;
            state_r     <= ST_EMPTY;
            valid_r     <= 1'b0;
          end else begin
            state_r <= ST_ONE;
          end
        end
        ST_TWO: begin
          if (ready_i) begin
            main_word_r <= skid_word_r;
            main_err_r  <= skid_err_r;
            skid_word_r <= '0;
            skid_err_r  <= 1'b0;
            state_r     <= ST_ONE;
            ready_r     <= 1'b1;
          end else begin
            state_r <= ST_TWO;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty buffer.
          state_r     <= ST_EMPTY;
          main_word_r <= '0;
          main_err_r  <= 1'b0;
          skid_word_r <= '0;
          skid_err_r  <= 1'b0;
          valid_r     <= 1'b0;
          ready_r     <= 1'b1;
        end
      endcase
    end
  end

  assign out_o       = main_word_r;
  assign range_err_o = main_err_r;
  assign valid_o     = valid_r;
  assign ready_o     = ready_r;

endmodule

// File: tb/tb_decoder_pipe_e.sv
// -----------------------------------------------------------------------------
// tb_decoder_pipe_e
//
// Drives three decoder_pipe_e instances from shared inputs: one-hot 5x32,
// thermometer 5x32 and one-hot 5x24 (out-of-range checking). Flow control
// does not depend on data, so one queue of pending transactions (capacity 2)
// predicts all three; expected words are computed arithmetically per mode.
// -----------------------------------------------------------------------------
module tb_decoder_pipe_e;

  typedef struct packed {
    logic [4:0] idx;
    logic       en;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  in_v;
  logic        en;
  logic        vin;
  logic        rdy;

  logic        oh_ready, oh_valid, oh_err;
  logic [31:0] oh_out;
  logic        th_ready, th_valid, th_err;
  logic [31:0] th_out;
  logic        rg_ready, rg_valid, rg_err;
  logic [23:0] rg_out;

  int vectors    = 0;
  int miscompares = 0;
  txn_t q[$];

  always #5 clk = ~clk;

  decoder_pipe_e #(.IN_WIDTH(5), .NUM_OUTPUTS(32), .THERMO(0)) u_onehot (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_v), .enable_i(en), .valid_i(vin),
    .ready_o(oh_ready), .out_o(oh_out), .range_err_o(oh_err),
    .valid_o(oh_valid), .ready_i(rdy)
  );

  decoder_pipe_e #(.IN_WIDTH(5), .NUM_OUTPUTS(32), .THERMO(1)) u_thermo (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_v), .enable_i(en), .valid_i(vin),
    .ready_o(th_ready), .out_o(th_out), .range_err_o(th_err),
    .valid_o(th_valid), .ready_i(rdy)
  );

  decoder_pipe_e #(.IN_WIDTH(5), .NUM_OUTPUTS(24), .THERMO(0)) u_range (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_v), .enable_i(en), .valid_i(vin),
    .ready_o(rg_ready), .out_o(rg_out), .range_err_o(rg_err),
    .valid_o(rg_valid), .ready_i(rdy)
  );

  function automatic logic [31:0] exp_onehot(input txn_t t);
    return t.en ? (32'h1 << t.idx) : 32'h0;
  endfunction

  function automatic logic [31:0] exp_thermo(input txn_t t);
    logic [63:0] w;
    int n;
    n = int'(t.idx) + 1;
    w = (64'h1 << n) - 64'h1;
    return t.en ? w[31:0] : 32'h0;
  endfunction

  function automatic logic [32:0] exp_range(input txn_t t);
    // returns {word, err} for the 24-output instance
    if (!t.en) return 33'h0;
    if (int'(t.idx) >= 24) return {32'h0, 1'b1};
    return {(32'h1 << t.idx), 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all outputs against the queue model, then advance one clock edge.
  task automatic cycle();
    txn_t hd;
    logic [32:0] rexp;
    logic exp_valid, exp_ready, acc, xfer;
    exp_valid = (q.size() > 0);
    exp_ready = (q.size() < 2);
    hd = '0;
    if (exp_valid) hd = q[0];
    rexp = exp_range(hd);
    chk("oh_valid", {31'h0, oh_valid}, {31'h0, exp_valid});
    chk("oh_ready", {31'h0, oh_ready}, {31'h0, exp_ready});
    chk("oh_out",   oh_out, exp_onehot(hd));
    chk("oh_err",   {31'h0, oh_err}, 32'h0);
    chk("th_valid", {31'h0, th_valid}, {31'h0, exp_valid});
    chk("th_ready", {31'h0, th_ready}, {31'h0, exp_ready});
    chk("th_out",   th_out, exp_thermo(hd));
    chk("th_err",   {31'h0, th_err}, 32'h0);
    chk("rg_valid", {31'h0, rg_valid}, {31'h0, exp_valid});
    chk("rg_out",   {8'h0, rg_out}, rexp[32:1]);
    chk("rg_err",   {31'h0, rg_err}, {31'h0, rexp[0]});
    if (!rst_n) begin
      q.delete();
    end else begin
      acc  = vin && (q.size() < 2);
      xfer = (q.size() > 0) && rdy;
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back('{idx: in_v, en: en});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] i, input logic e, input logic r);
    vin = v; in_v = i; en = e; rdy = r;
  endtask

  initial begin
    // Reset held for three edges with a live transaction on the inputs.
    rst_n = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    q.delete();
    cycle();
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 5'd7, 1'b1, 1'b1);
    repeat (3) cycle();

    // One-hot sweep back to back.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 1'b1, 1'b1);
      cycle();
    end
    drive(1'b0, 5'd0, 1'b1, 1'b1);
    repeat (2) cycle();

    // Thermometer values and a disabled request.
    drive(1'b1, 5'd4, 1'b1, 1'b1);  cycle();
    drive(1'b1, 5'd31, 1'b1, 1'b1); cycle();
    drive(1'b1, 5'd9, 1'b0, 1'b1);  cycle();

    // Out-of-range boundary on the 24-output instance, enabled and disabled.
    drive(1'b1, 5'd23, 1'b1, 1'b1); cycle();
    drive(1'b1, 5'd24, 1'b1, 1'b1); cycle();
    drive(1'b1, 5'd31, 1'b1, 1'b1); cycle();
    drive(1'b1, 5'd24, 1'b0, 1'b1); cycle();
    drive(1'b1, 5'd31, 1'b0, 1'b1); cycle();
    drive(1'b0, 5'd0, 1'b1, 1'b1);  repeat (2) cycle();

    // Backpressure: 1 and 2 fill the buffer, 3 is held until space frees.
    drive(1'b1, 5'd1, 1'b1, 1'b0); cycle();
    drive(1'b1, 5'd2, 1'b1, 1'b0); cycle();
    drive(1'b1, 5'd3, 1'b1, 1'b0); cycle();
    cycle();
    drive(1'b1, 5'd3, 1'b1, 1'b1); cycle();
    cycle();
    drive(1'b0, 5'd0, 1'b1, 1'b1); repeat (3) cycle();

    // Reset while both entries are full.
    drive(1'b1, 5'd5, 1'b1, 1'b0); cycle();
    drive(1'b1, 5'd6, 1'b1, 1'b0); cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 1'b1, 1'b1);
    repeat (3) cycle();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) != 0));
      cycle();
    end
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 1'b1, 1'b1);
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder_pipe_e.md
# decoder_pipe_e

Parametrised, pipelined, enabled binary-to-one-hot/thermometer decoder with valid/ready flow control and a two-entry skid buffer. Generalises the fixed 5x32 enabled decoder to any input width, non-power-of-two output counts and a thermometer mode, and flags out-of-range indices. Sits between the instruction-decode stage and register-file / bank write-enable fan-out, where a registered, back-pressurable decode is needed.

## Interface
- IN_WIDTH, 5, index width in bits; legal range 1..8.
- NUM_OUTPUTS, 2**IN_WIDTH, number of decoded lines; legal range 2..2**IN_WIDTH; elaboration fails outside this range.
- THERMO, 0, 0 = one-hot decode; 1 = thermometer decode.

- clk_i  input  1  single clock, all state updates on rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- in_i  input  IN_WIDTH  index to decode.
- enable_i  input  1  decode enable; 0 produces an all-zero (no-op) word that still flows.
- valid_i  input  1  upstream has a transaction.
- ready_o  output  1  block can accept a transaction this cycle.
- out_o  output  NUM_OUTPUTS  decoded word of the head transaction.
- range_err_o  output  1  head transaction had in_i >= NUM_OUTPUTS with enable_i=1.
- valid_o  output  1  out_o / range_err_o are valid.
- ready_i  input  1  downstream accepts the head transaction this cycle.

## Operation
- Accept: valid_i && ready_o on a rising edge. Transfer out: valid_o && ready_i.
- Decode at input side, stored as {word, err}:
  - enable_i=0: word=0, err=0.
  - enable_i=1, in_i < NUM_OUTPUTS: THERMO=0 -> word[in_i]=1 only; THERMO=1 -> word[k]=1 for all k <= in_i.
  - enable_i=1, in_i >= NUM_OUTPUTS: word=0, err=1.
- Storage: main register (drives outputs) plus one skid register.
- States: EMPTY, ONE (main full), TWO (main+skid full).
  - EMPTY: accept -> ONE, main <= new.
  - ONE: accept & ready_i -> ONE, main <= new; accept & !ready_i -> TWO, skid <= new; !accept & ready_i -> EMPTY; else hold.
  - TWO: ready_i -> ONE, main <= skid; else hold. No accept possible.
- ready_o = (state != TWO), derived from registered state only (no combinational ready_i -> ready_o path).
- valid_o = (state != EMPTY).
- out_o and range_err_o are forced 0 whenever valid_o=0.
- Ordering strictly FIFO; no transaction is dropped or duplicated.
- While valid_o=1 and ready_i=0, out_o/range_err_o are stable.

## Timing
- Latency: transaction accepted at edge N appears on out_o/valid_o after edge N, i.e. visible in cycle N+1 (1 cycle), when state was EMPTY or ONE with ready_i=1.
- Throughput: 1 transaction/cycle with ready_i held high.
- Reset: any edge with rst_ni=0 forces state EMPTY, main and skid cleared; inputs ignored on that edge. After reset: valid_o=0, ready_o=1, out_o=0, range_err_o=0.
- Reset mid-operation: buffered transactions in main/skid are discarded; no output pulse after reset deasserts.
- Simultaneous accept and transfer in ONE: head leaves and new entry takes main in the same edge; valid_o stays 1.
- ready_o deasserts the cycle after entering TWO; reasserts the cycle after the first downstream transfer from TWO.

## Test plan
- Reset: hold rst_ni=0 for 3 cycles with valid_i=1, in_i=7 -> after release valid_o=0, ready_o=1, out_o=0; no transaction emerges.
- One-hot sweep (IN_WIDTH=5, NUM_OUTPUTS=32, THERMO=0, ready_i=1): in_i=0..31, enable_i=1, back-to-back -> out_o=32'h1<<i one cycle later each, range_err_o=0, one per cycle.
- Thermometer + disable (THERMO=1): in_i=4, enable_i=1 -> out_o=32'h1F; in_i=31 -> 32'hFFFF_FFFF; in_i=9, enable_i=0 -> out_o=0, valid_o=1, range_err_o=0.
- Out of range (NUM_OUTPUTS=24): in_i=23 -> out_o=24'h80_0000, err=0; in_i=24 and 31 -> out_o=0, range_err_o=1; same with enable_i=0 -> err=0.
- Backpressure: stream in_i=1,2,3 with ready_i=0 -> after 2 accepts ready_o=0, out_o holds 32'h2; release ready_i -> outputs 32'h2, 32'h4, then 32'h8 accepted and delivered, order preserved, nothing lost.
- Reset in TWO state: fill both entries, assert rst_ni=0 for one edge -> valid_o=0, ready_o=1 next cycle; buffered entries never appear.
